// File: rtl/sr_latch.sv
// Clocked set/reset storage: WIDTH independent SR cells with a registered complement
// and a per-cell flag for s=r=1. The s=r=1 response is chosen by INVALID_MODE.
module sr_latch #(
   parameter int unsigned WIDTH        = 1,
   parameter int unsigned INVALID_MODE = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] s,
   input  logic [WIDTH-1:0] r,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] q_,
   output logic [WIDTH-1:0] invalid
);

   // Out-of-range modes fall back to NOR-latch emulation
   localparam int unsigned MODE = (INVALID_MODE > 3) ? 0 : INVALID_MODE;

   logic [WIDTH-1:0] r_q;
   logic [WIDTH-1:0] r_qn;
   logic [WIDTH-1:0] r_inv;
   logic             r_init;
   logic [WIDTH-1:0] w_q_nxt;
   logic [WIDTH-1:0] w_qn_nxt;
   logic [WIDTH-1:0] w_inv_nxt;

   for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      logic w_q_c;
      logic w_qn_c;
      logic w_inv_c;

      always_comb begin
         w_q_c   = r_q[i];
         w_qn_c  = r_qn[i];
         w_inv_c = 1'b0;
         unique case ({s[i], r[i]})
            2'b01: begin
               w_q_c  = 1'b0;
               w_qn_c = 1'b1;
            end
            2'b10: begin
               w_q_c  = 1'b1;
               w_qn_c = 1'b0;
            end
            2'b11: begin
               w_inv_c = 1'b1;
               case (MODE)
                  1: begin
                     w_q_c  = r_q[i];
                     w_qn_c = r_qn[i];
                  end
                  2: begin
                     w_q_c  = 1'b1;
                     w_qn_c = 1'b0;
                  end
                  3: begin
                     w_q_c  = 1'b0;
                     w_qn_c = 1'b1;
                  end
                  default: begin
                     w_q_c  = 1'b0;
                     w_qn_c = 1'b0;
                  end
               endcase
            end
            default: ;
         endcase
      end

      assign w_q_nxt[i]   = w_q_c;
      assign w_qn_nxt[i]  = w_qn_c;
      assign w_inv_nxt[i] = w_inv_c;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_q    <= '0;
         r_qn   <= '1;
         r_inv  <= '0;
         r_init <= 1'b1;
      end else begin
         r_q   <= w_q_nxt;
         r_qn  <= w_qn_nxt;
         r_inv <= w_inv_nxt;
      end
   end

   assign q       = r_q;
   assign q_      = r_qn;
   assign invalid = r_inv;

   // q/q_ are never both 1; outside NOR emulation they are always complementary
   always @(posedge clk) begin
      if (!rst && r_init) begin
         assert ((r_q & r_qn) == '0);
         if (MODE != 0) assert (r_qn == ~r_q);
      end
   end

endmodule

// File: tb/tb_sr_latch.sv
// Bench for sr_latch: five 1-bit instances (modes 0,1,2,3 and illegal 7) plus a 4-bit
// mode-0 instance, checked every cycle against a rule-table model plus literal expectations.
module tb_sr_latch;

   logic       clk;
   logic       rst;
   logic       s1, r1;
   logic [3:0] s4, r4;

   logic       dq  [5];
   logic       dqn [5];
   logic       dinv[5];
   logic [3:0] wq, wqn, winv;

   int n_tests = 0;
   int n_fail  = 0;

   sr_latch #(.WIDTH(1), .INVALID_MODE(0)) u_m0 (.clk(clk), .rst(rst), .s(s1), .r(r1),
      .q(dq[0]), .q_(dqn[0]), .invalid(dinv[0]));
   sr_latch #(.WIDTH(1), .INVALID_MODE(1)) u_m1 (.clk(clk), .rst(rst), .s(s1), .r(r1),
      .q(dq[1]), .q_(dqn[1]), .invalid(dinv[1]));
   sr_latch #(.WIDTH(1), .INVALID_MODE(2)) u_m2 (.clk(clk), .rst(rst), .s(s1), .r(r1),
      .q(dq[2]), .q_(dqn[2]), .invalid(dinv[2]));
   sr_latch #(.WIDTH(1), .INVALID_MODE(3)) u_m3 (.clk(clk), .rst(rst), .s(s1), .r(r1),
      .q(dq[3]), .q_(dqn[3]), .invalid(dinv[3]));
   sr_latch #(.WIDTH(1), .INVALID_MODE(7)) u_m7 (.clk(clk), .rst(rst), .s(s1), .r(r1),
      .q(dq[4]), .q_(dqn[4]), .invalid(dinv[4]));
   sr_latch #(.WIDTH(4), .INVALID_MODE(0)) u_w4 (.clk(clk), .rst(rst), .s(s4), .r(r4),
      .q(wq), .q_(wqn), .invalid(winv));

   always #5 clk = ~clk;

   // Model state: what each cell must show after the most recent edge
   int   modes[5] = '{0, 1, 2, 3, 7};
   logic mq[5], mqn[5], minv[5];
   logic [3:0] mwq, mwqn, mwinv;
   bit   model_ok = 0;

   // Returns {q, q_, invalid} from the rule table for one cell
   function automatic logic [2:0] rule(input int mode, input logic s, input logic r,
                                       input logic q, input logic qn);
      int m;
      m = (mode > 3) ? 0 : mode;
      if (!s && !r) return {q, qn, 1'b0};
      if (!s &&  r) return 3'b010;
      if ( s && !r) return 3'b100;
      if (m == 1) return {q, qn, 1'b1};
      if (m == 2) return 3'b101;
      if (m == 3) return 3'b011;
      return 3'b001;
   endfunction

   always @(posedge clk) begin
      logic [2:0] o;
      if (rst) begin
         for (int k = 0; k < 5; k++) begin
            mq[k] = 1'b0; mqn[k] = 1'b1; minv[k] = 1'b0;
         end
         mwq = 4'h0; mwqn = 4'hF; mwinv = 4'h0;
         model_ok = 1;
      end else if (model_ok) begin
         for (int k = 0; k < 5; k++) begin
            o = rule(modes[k], s1, r1, mq[k], mqn[k]);
            {mq[k], mqn[k], minv[k]} = o;
         end
         for (int b = 0; b < 4; b++) begin
            o = rule(0, s4[b], r4[b], mwq[b], mwqn[b]);
            {mwq[b], mwqn[b], mwinv[b]} = o;
         end
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Every-cycle comparison against the model
   always @(negedge clk) begin
      if (model_ok) begin
         for (int k = 0; k < 5; k++) begin
            chk($sformatf("model_m%0d", modes[k]), 64'({dq[k], dqn[k], dinv[k]}),
                64'({mq[k], mqn[k], minv[k]}));
         end
         chk("model_w4", 64'({wq, wqn, winv}), 64'({mwq, mwqn, mwinv}));
      end
   end

   task automatic step(input logic i_rst, input logic i_s, input logic i_r,
                       input logic [3:0] i_s4, input logic [3:0] i_r4);
      rst = i_rst; s1 = i_s; r1 = i_r; s4 = i_s4; r4 = i_r4;
      @(posedge clk);
      #1;
   endtask

   // Literal check of the 1-bit instance k: {q, q_, invalid}
   task automatic lit(input string name, input int k, input logic [2:0] exp);
      chk(name, 64'({dq[k], dqn[k], dinv[k]}), 64'(exp));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      clk = 1'b0;
      // Reset held two cycles while set is requested
      step(1'b1, 1'b1, 1'b0, 4'h0, 4'h0);
      lit("rst1_m0", 0, 3'b010);
      chk("rst1_w4", 64'({wq, wqn, winv}), 64'({4'h0, 4'hF, 4'h0}));
      step(1'b1, 1'b1, 1'b0, 4'h0, 4'h0);
      lit("rst2_m0", 0, 3'b010);

      // Base sequence plus mode sweep from q=0
      step(1'b0, 1'b0, 1'b1, 4'h0, 4'h0);
      lit("reset_m0", 0, 3'b010);
      step(1'b0, 1'b1, 1'b1, 4'h0, 4'h0);
      lit("inv_m0", 0, 3'b001);
      lit("inv_m1_from0", 1, 3'b011);
      lit("inv_m2_from0", 2, 3'b101);
      lit("inv_m3_from0", 3, 3'b011);
      lit("inv_m7", 4, 3'b001);
      step(1'b0, 1'b1, 1'b0, 4'h0, 4'h0);
      lit("set_m0", 0, 3'b100);
      lit("set_m1", 1, 3'b100);

      // From q=1: s=r=1 across all modes
      step(1'b0, 1'b1, 1'b1, 4'h0, 4'h0);
      lit("inv2_m0", 0, 3'b001);
      lit("sweep_m1", 1, 3'b101);
      lit("sweep_m2", 2, 3'b101);
      lit("sweep_m3", 3, 3'b011);
      lit("sweep_m7", 4, 3'b001);
      step(1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
      lit("hold00_m0", 0, 3'b000);
      lit("hold_m1", 1, 3'b100);
      step(1'b0, 1'b0, 1'b1, 4'h0, 4'h0);
      lit("leave00_m0", 0, 3'b010);

      // Latency: set driven just after an edge lands exactly one edge later
      s1 = 1'b1; r1 = 1'b0;
      #2;
      lit("latency_before", 0, 3'b010);
      @(posedge clk);
      #1;
      lit("latency_after", 0, 3'b100);

      // Reset overrides a concurrent set, then set resumes
      step(1'b1, 1'b1, 1'b0, 4'h0, 4'h0);
      lit("rstprio_m0", 0, 3'b010);
      step(1'b0, 1'b1, 1'b0, 4'h0, 4'h0);
      lit("rstrel_m0", 0, 3'b100);

      // Multi-cell independence
      step(1'b0, 1'b0, 1'b0, 4'b0101, 4'b0011);
      chk("w4_mix", 64'({wq, wqn, winv}), 64'({4'b0100, 4'b1010, 4'b0001}));
      step(1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000);
      chk("w4_hold", 64'({wq, wqn, winv}), 64'({4'b0100, 4'b1010, 4'b0000}));
      step(1'b0, 1'b0, 1'b0, 4'b1111, 4'b1111);
      chk("w4_allinv", 64'({wq, wqn, winv}), 64'({4'b0000, 4'b0000, 4'b1111}));
      step(1'b0, 1'b0, 1'b0, 4'b1001, 4'b0110);
      chk("w4_restore", 64'({wq, wqn, winv}), 64'({4'b1001, 4'b0110, 4'b0000}));

      // Mixed traffic checked by the model alone
      for (int i = 0; i < 40; i++) begin
         step(1'($urandom_range(0, 15) == 0), 1'($urandom), 1'($urandom),
              4'($urandom), 4'($urandom));
      end

      @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
